// File: rtl/reduce_result_dispatch_if.sv
// Result-dispatch port bundle: capture input, network and host output handshakes, status.
interface reduce_result_dispatch_if #(
    parameter int DataWidth = 64,
    parameter int FifoAw    = 2
);
    logic                 res_valid;
    logic [DataWidth-1:0] res_packet;
    logic                 net_valid;
    logic                 net_ready;
    logic [DataWidth-1:0] net_packet;
    logic                 host_valid;
    logic                 host_ready;
    logic [DataWidth-1:0] host_packet;
    logic                 busy;
    logic                 overflow;
    logic [FifoAw:0]      fifo_count;

    modport master (
        output res_valid, res_packet, net_ready, host_ready,
        input  net_valid, net_packet, host_valid, host_packet, busy, overflow, fifo_count
    );

    modport slave (
        input  res_valid, res_packet, net_ready, host_ready,
        output net_valid, net_packet, host_valid, host_packet, busy, overflow, fifo_count
    );
endinterface

// File: rtl/reduce_result_dispatch.sv
// Buffers completed reductions, rewrites routing and sends to tree parent (net) or host (root).
// Optional RESULT_BCAST_EN: after an allreduce reaches the host, fan the result out to every non-root rank.
module reduce_result_dispatch #(
    parameter int DataWidth = 64,
    parameter int FifoDepth = 4,
    parameter int FifoAw    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    reduce_result_dispatch_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NET   = 2'd1,
        S_HOST  = 2'd2
`ifdef RESULT_BCAST_EN
        ,S_BCAST = 2'd3
`endif
    } state_e;

    localparam logic [FifoAw:0] FullCount = (FifoAw+1)'(FifoDepth);

    logic [DataWidth-1:0] mem_q [FifoDepth];
    logic [FifoAw-1:0]    wr_ptr_q, rd_ptr_q;
    logic [FifoAw:0]      count_q;
    logic                 overflow_q;
    logic                 full, empty, push, pop;
    logic [DataWidth-1:0] head;

    state_e               state_q, state_d;
    logic [DataWidth-1:0] pkt_q, pkt_d;
    logic                 take;
    logic                 net_active;

    function automatic logic [DataWidth-1:0] rewrite(input logic [DataWidth-1:0] p);
        logic [2:0] rank, root, v_m1, dst;
        logic [DataWidth-1:0] r;
        rank = p[39:37];
        root = p[42:40];
        v_m1 = rank - root - 3'd1;
        if (rank != root && p[51:50] == 2'b01)
            dst = root + (v_m1 >> 1);
        else
            dst = root;
        r        = p;
        r[63]    = 1'b1;
        r[62]    = 1'b1;
        r[61:59] = rank;
        r[58:56] = dst;
        return r;
    endfunction

`ifdef RESULT_BCAST_EN
    // Root field of the held packet survives the rewrite, so it drives src/skip for every step.
    function automatic logic [DataWidth-1:0] bcast_step(input logic [DataWidth-1:0] p,
                                                       input logic [2:0] r);
        logic [DataWidth-1:0] q;
        q        = p;
        q[63]    = 1'b1;
        q[62]    = 1'b0;
        q[55:52] = 4'h3;
        q[61:59] = p[42:40];
        q[58:56] = r;
        return q;
    endfunction

    logic [3:0] bc_cs, bc_root, bc_first, bc_next;
`endif

    // Full is judged on the registered count, so a pop in the same cycle does not save a write.
    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    assign push  = bus.res_valid && !full;
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= bus.res_packet;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.res_valid && full)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        pop     = 1'b0;
        take    = 1'b0;
`ifdef RESULT_BCAST_EN
        bc_cs    = {1'b0, pkt_q[45:43]};
        bc_root  = {1'b0, pkt_q[42:40]};
        bc_first = (bc_root == 4'd0) ? 4'd1 : 4'd0;
        bc_next  = {1'b0, pkt_q[58:56]} + 4'd1;
        if (bc_next == bc_root)
            bc_next = bc_next + 4'd1;
`endif
        case (state_q)
            S_IDLE: take = 1'b1;
            S_NET:  take = bus.net_ready;
            S_HOST: begin
                if (bus.host_ready) begin
`ifdef RESULT_BCAST_EN
                    if (pkt_q[55:52] == 4'h2 && bc_cs > 4'd1) begin
                        state_d = S_BCAST;
                        pkt_d   = bcast_step(pkt_q, bc_first[2:0]);
                    end else begin
                        take = 1'b1;
                    end
`else
                    take = 1'b1;
`endif
                end
            end
`ifdef RESULT_BCAST_EN
            S_BCAST: begin
                if (bus.net_ready) begin
                    if (bc_next < bc_cs)
                        pkt_d = bcast_step(pkt_q, bc_next[2:0]);
                    else
                        state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Popping straight out of a completed handshake keeps one transfer per cycle.
        if (take) begin
            state_d = S_IDLE;
            if (!empty) begin
                pop = 1'b1;
                if (head[63]) begin
                    pkt_d   = rewrite(head);
                    state_d = (head[39:37] == head[42:40]) ? S_HOST : S_NET;
                end
            end
        end
    end

`ifdef RESULT_BCAST_EN
    assign net_active = (state_q == S_NET) || (state_q == S_BCAST);
`else
    assign net_active = (state_q == S_NET);
`endif

    assign bus.net_valid   = net_active;
    assign bus.net_packet  = net_active ? pkt_q : '0;
    assign bus.host_valid  = (state_q == S_HOST);
    assign bus.host_packet = (state_q == S_HOST) ? pkt_q : '0;
    assign bus.busy        = !empty || (state_q != S_IDLE);
    assign bus.overflow    = overflow_q;
    assign bus.fifo_count  = count_q;
endmodule

// File: tb/tb_reduce_result_dispatch.sv
// Scoreboard bench for reduce_result_dispatch: directed cases plus throttled random traffic.
module tb_reduce_result_dispatch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reduce_result_dispatch_if #(.DataWidth(64), .FifoAw(2)) bus();

    reduce_result_dispatch #(.DataWidth(64), .FifoDepth(4), .FifoAw(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int n_net  = 0;
    int n_host = 0;
    logic [63:0] net_q[$];
    logic [63:0] host_q[$];
    logic        held_vld = 1'b0;
    logic [63:0] held_pkt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each accepted packet yields its rewritten copy (and broadcast copies) in order.
    task automatic model_push(input logic [63:0] p);
        int rank, root, alg, cs, dst;
        logic [63:0] e, b;
        if (!p[63]) return;
        rank = int'(p[39:37]);
        root = int'(p[42:40]);
        alg  = int'(p[51:50]);
        cs   = int'(p[45:43]);
        e = p;
        e[62] = 1'b1;
        e[61:59] = p[39:37];
        if (rank == root) begin
            e[58:56] = p[42:40];
            host_q.push_back(e);
`ifdef RESULT_BCAST_EN
            if (p[55:52] == 4'h2 && cs > 1) begin
                for (int r = 0; r < cs; r++) begin
                    if (r == root) continue;
                    b = e;
                    b[62] = 1'b0;
                    b[55:52] = 4'h3;
                    b[61:59] = p[42:40];
                    dst = r;
                    b[58:56] = dst[2:0];
                    net_q.push_back(b);
                end
            end
`endif
        end else begin
            if (alg == 1)
                dst = (root + (((rank - root - 1) + 16) % 8) / 2) % 8;
            else
                dst = root;
            e[58:56] = dst[2:0];
            net_q.push_back(e);
        end
    endtask

    task automatic send(input logic [63:0] p, input bit accepted);
        bus.res_packet = p;
        bus.res_valid  = 1'b1;
        if (accepted) model_push(p);
        @(posedge clk); #1;
        bus.res_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [63:0] mk(input int rank, input int root, input int alg,
                                       input int typ, input int cs, input logic [31:0] pay);
        logic [63:0] p;
        p = {$urandom, $urandom};
        p[63] = 1'b1;
        p[39:37] = rank[2:0];
        p[42:40] = root[2:0];
        p[51:50] = alg[1:0];
        p[55:52] = typ[3:0];
        p[45:43] = cs[2:0];
        p[31:0]  = pay;
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            held_vld <= 1'b0;
        end else begin
            if (bus.net_valid && bus.host_valid)
                check("one_valid", 64'(bus.net_valid & bus.host_valid), 64'd0);
            if (held_vld && bus.net_valid)
                check("net_stable", bus.net_packet, held_pkt);
            held_vld <= bus.net_valid && !bus.net_ready;
            held_pkt <= bus.net_packet;
            if (bus.net_valid && bus.net_ready) begin
                n_net++;
                if (net_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL net_unexpected: got %h required none", bus.net_packet);
                end else begin
                    check("net_pkt", bus.net_packet, net_q.pop_front());
                end
            end
            if (bus.host_valid && bus.host_ready) begin
                n_host++;
                if (host_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL host_unexpected: got %h required none", bus.host_packet);
                end else begin
                    check("host_pkt", bus.host_packet, host_q.pop_front());
                end
            end
        end
    end

    initial begin
        int base_net, base_host;
        logic [63:0] p;
        bus.res_valid  = 1'b0;
        bus.res_packet = '0;
        bus.net_ready  = 1'b0;
        bus.host_ready = 1'b0;

        // T1 reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        check("rst_net_valid",  64'(bus.net_valid), 64'd0);
        check("rst_host_valid", 64'(bus.host_valid), 64'd0);
        check("rst_net_pkt",    bus.net_packet, 64'd0);
        check("rst_host_pkt",   bus.host_packet, 64'd0);
        check("rst_busy",       64'(bus.busy), 64'd0);
        check("rst_overflow",   64'(bus.overflow), 64'd0);
        check("rst_count",      64'(bus.fifo_count), 64'd0);

        // T2 flat route and minimum latency
        bus.net_ready = 1'b1;
        base_net = n_net;
        send(mk(3, 0, 0, 1, 4, 32'h3F80_0000), 1'b1);
        check("t2_lat_early", 64'(bus.net_valid), 64'd0);
        idle(1);
        check("t2_lat_valid", 64'(bus.net_valid), 64'd1);
        idle(4);
        check("t2_one_xfer", 64'(n_net - base_net), 64'd1);

        // T3 binary tree parent and root to host
        bus.host_ready = 1'b1;
        base_net = n_net; base_host = n_host;
        send(mk(7, 2, 1, 1, 8, 32'h1234_5678), 1'b1);
        send(mk(2, 2, 1, 1, 8, 32'hCAFE_F00D), 1'b1);
        idle(6);
        check("t3_net_cnt",  64'(n_net - base_net), 64'd1);
        check("t3_host_cnt", 64'(n_host - base_host), 64'd1);

        // Invalid entries are discarded silently
        base_net = n_net;
        p = mk(4, 1, 0, 1, 8, 32'h0);
        p[63] = 1'b0;
        send(p, 1'b0);
        idle(4);
        check("disc_busy",  64'(bus.busy), 64'd0);
        check("disc_count", 64'(n_net - base_net), 64'd0);

        // T4 back-pressure fills buffer, sixth pulse dropped
        bus.net_ready = 1'b0;
        base_net = n_net;
        for (int i = 0; i < 6; i++)
            send(mk(5, 0, 0, 1, 8, 32'(i)), i < 5);
        check("t4_overflow", 64'(bus.overflow), 64'd1);
        check("t4_count",    64'(bus.fifo_count), 64'd4);
        bus.net_ready = 1'b1;
        idle(10);
        check("t4_drained", 64'(n_net - base_net), 64'd5);

        // T5 reset mid-transfer purges everything
        bus.net_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(mk(6, 1, 0, 1, 8, 32'(100 + i)), 1'b1);
        check("t5_held", 64'(bus.net_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_net_valid", 64'(bus.net_valid), 64'd0);
        check("t5_count",     64'(bus.fifo_count), 64'd0);
        net_q.delete();
        host_q.delete();
        rst = 1'b0;
        bus.net_ready = 1'b1;
        base_net = n_net;
        idle(10);
        check("t5_no_stale", 64'(n_net - base_net), 64'd0);
        check("t5_overflow", 64'(bus.overflow), 64'd0);

`ifdef RESULT_BCAST_EN
        // T6 allreduce broadcast fan-out
        base_net = n_net; base_host = n_host;
        send(mk(1, 1, 0, 2, 4, 32'hDEAD_BEEF), 1'b1);
        idle(12);
        check("t6_host_cnt", 64'(n_host - base_host), 64'd1);
        check("t6_net_cnt",  64'(n_net - base_net), 64'd3);
        check("t6_idle",     64'(bus.busy), 64'd0);
`endif

        // Random traffic, throttled so the buffer can never overflow
        for (int i = 0; i < 600; i++) begin
            bus.net_ready  = ($urandom % 4) != 0;
            bus.host_ready = ($urandom % 4) != 0;
            if ((net_q.size() + host_q.size()) < 4 && ($urandom % 2) == 1) begin
                p = {$urandom, $urandom};
                p[63] = 1'b1;
                if ($urandom % 3 == 0) p[39:37] = p[42:40];
                if ($urandom % 4 == 0) p[55:52] = 4'h2;
                send(p, 1'b1);
            end else begin
                idle(1);
            end
        end
        bus.net_ready  = 1'b1;
        bus.host_ready = 1'b1;
        for (int i = 0; i < 2000 && (net_q.size() + host_q.size()) != 0; i++)
            @(posedge clk);
        idle(3);
        check("end_net_q",    64'(net_q.size()), 64'd0);
        check("end_host_q",   64'(host_q.size()), 64'd0);
        check("end_busy",     64'(bus.busy), 64'd0);
        check("end_overflow", 64'(bus.overflow), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
